// File: rtl/output_pipe_pkg.sv
// Shared definitions for the output streaming pipeline: transmitter FSM states
// and frame sizing constants.
package output_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } tx_state_t;

    localparam int unsigned FRAME_BYTES        = 307200;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO whose head is presented through a registered output stage;
// the byte held in that stage still occupies its FIFO slot until the sink takes it.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic       o_push_ok,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_head_valid,
    output logic [7:0] o_head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_rd_next;
    logic        r_head_valid;
    logic [7:0]  r_head_data;
    logic        w_pop;
    logic        w_push;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);

    // A pop frees the head slot in the same cycle, so a full FIFO can still take a byte
    assign w_pop     = i_pop && r_head_valid;
    assign w_push    = i_push && (!o_full || w_pop);
    assign w_rd_next = w_pop ? (r_rd_ptr + {{AW{1'b0}}, 1'b1}) : r_rd_ptr;

    assign o_push_ok    = w_push;
    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;

    // Storage array write port
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Pointers and registered head; a byte written this edge becomes visible one edge later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_head_valid <= 1'b0;
            r_head_data  <= 8'h00;
        end else begin
            r_rd_ptr     <= w_rd_next;
            r_head_valid <= (r_wr_ptr != w_rd_next);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (r_wr_ptr != w_rd_next) begin
                r_head_data <= r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/output_stream_tx.sv
// Frame-oriented byte transmitter between the output fetch stage and an external sink.
// Optional 16-bit frame checksum output enabled by defining OUTPUT_CHECKSUM_EN.
module output_stream_tx
    import output_pipe_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W      = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic [15:0]      in_addr,
    input  logic             in_done,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             frame_sel,
`ifdef OUTPUT_CHECKSUM_EN
    output logic [15:0]      checksum,
`endif
    output logic [CNT_W-1:0] byte_count,
    output logic             overflow,
    output logic             tx_done
);

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic             w_push_req;
    logic             w_frame_start;
    logic             w_push_ok;
    logic             w_full;
    logic             w_empty;
    logic             w_out_valid;
    logic [7:0]       w_out_data;
    logic             r_frame_sel;
    logic [CNT_W-1:0] r_byte_count;
    logic             r_overflow;
    logic             r_tx_done;
    logic             w_unused;

    assign w_unused = ^{in_addr[14:0], w_full};

    // Bytes are only taken while a frame is being streamed, or as its first byte
    assign w_frame_start = in_valid && (r_state == ST_IDLE);
    assign w_push_req    = in_valid && ((r_state == ST_IDLE) || (r_state == ST_STREAM));

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_push       (w_push_req),
        .i_push_data  (in_data),
        .i_pop        (out_ready),
        .o_push_ok    (w_push_ok),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head_valid (w_out_valid),
        .o_head_data  (w_out_data)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) w_state_next = ST_STREAM;
                else          w_state_next = ST_IDLE;
            end
            ST_STREAM: begin
                if (in_done) w_state_next = ST_DRAIN;
                else         w_state_next = ST_STREAM;
            end
            ST_DRAIN: begin
                if (w_empty && !w_out_valid) w_state_next = ST_DONE;
                else                         w_state_next = ST_DRAIN;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Frame bookkeeping: select capture, accepted-byte count, sticky drop flag, done pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_sel  <= 1'b0;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_tx_done <= (w_state_next == ST_DONE);
            if (w_frame_start) begin
                r_frame_sel  <= in_addr[15];
                r_byte_count <= w_push_ok ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
                r_overflow   <= !w_push_ok;
            end else if (w_push_req) begin
                if (w_push_ok) begin
                    if (r_byte_count != {CNT_W{1'b1}}) begin
                        r_byte_count <= r_byte_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef OUTPUT_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Running sum of accepted bytes; only STREAM/IDLE push, so it freezes from DRAIN on
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= 16'h0000;
        end else if (w_frame_start) begin
            r_checksum <= w_push_ok ? {8'h00, in_data} : 16'h0000;
        end else if (w_push_req && w_push_ok) begin
            r_checksum <= r_checksum + {8'h00, in_data};
        end
    end

    assign checksum = r_checksum;
`endif

    assign out_valid  = w_out_valid;
    assign out_data   = w_out_data;
    assign frame_sel  = r_frame_sel;
    assign byte_count = r_byte_count;
    assign overflow   = r_overflow;
    assign tx_done    = r_tx_done;

endmodule

// File: tb/tb_output_stream_tx.sv
// Directed self-checking bench for output_stream_tx (FIFO_DEPTH=16, CNT_W=20);
// the checksum step is compiled in when OUTPUT_CHECKSUM_EN is defined.
module tb_output_stream_tx;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [15:0] in_addr;
    logic        in_done;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        frame_sel;
    logic [19:0] byte_count;
    logic        overflow;
    logic        tx_done;
`ifdef OUTPUT_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int         tests = 0;
    int         fails = 0;
    int         tx_cnt = 0;
    int         tx_before;
    logic [7:0] rx_q[$];

    always #5 clock = ~clock;

    output_stream_tx #(
        .FIFO_DEPTH (16),
        .CNT_W      (20)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .in_done    (in_done),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_sel  (frame_sel),
`ifdef OUTPUT_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .byte_count (byte_count),
        .overflow   (overflow),
        .tx_done    (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record the byte the sink takes at the coming edge, advance, then sample 1 time unit later
    task automatic cycle();
        if (out_valid && out_ready) rx_q.push_back(out_data);
        @(posedge clock);
        #1;
        if (tx_done) tx_cnt++;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [15:0] a);
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic end_frame(input int n);
        in_done = 1'b1;
        cycle();
        in_done = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_addr   = 16'h0000;
        in_done   = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_flags", 32'({frame_sel, overflow, tx_done}), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cycle();

        // 16 bytes in order, ready held high
        out_ready = 1'b1;
        rx_q.delete();
        tx_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i), 16'h0000);
            if (i == 0) check("lat_not_yet", 32'(out_valid), 32'd0);
            if (i == 1) check("lat_valid", 32'({out_valid, out_data}), 32'h100);
        end
        end_frame(10);
        check("seq_byte_count", 32'(byte_count), 32'd16);
        check("seq_rx_size", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) check("seq_rx_data", 32'(rx_q[i]), 32'(i));
        check("seq_tx_pulses", 32'(tx_cnt), 32'd1);
        check("seq_overflow", 32'(overflow), 32'd0);

        // 20 bytes into a stalled sink: 16 kept, 4 dropped
        out_ready = 1'b0;
        rx_q.delete();
        tx_cnt = 0;
        for (int i = 0; i < 20; i++) push_byte(8'h40 + 8'(i), 16'h0000);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_byte_count", 32'(byte_count), 32'd16);
        cycle();
        check("ovf_hold", 32'({out_valid, out_data}), 32'h140);
        out_ready = 1'b1;
        end_frame(25);
        check("ovf_rx_size", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) check("ovf_rx_data", 32'(rx_q[i]), 32'h40 + 32'(i));
        check("ovf_tx_pulses", 32'(tx_cnt), 32'd1);

        // Full FIFO with a pop in the same cycle still accepts the push
        out_ready = 1'b0;
        rx_q.delete();
        tx_cnt = 0;
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 16'h0000);
        check("full_no_ovf", 32'(overflow), 32'd0);
        check("full_count", 32'(byte_count), 32'd16);
        out_ready = 1'b1;
        push_byte(8'h90, 16'h0000);
        check("full_push_ovf", 32'(overflow), 32'd0);
        check("full_push_count", 32'(byte_count), 32'd17);
        end_frame(25);
        check("full_rx_size", 32'(rx_q.size()), 32'd17);
        check("full_rx_first", 32'(rx_q[0]), 32'h80);
        check("full_rx_last", 32'(rx_q[16]), 32'h90);
        check("full_tx_pulses", 32'(tx_cnt), 32'd1);

        // Frame select captured on the first byte only
        push_byte(8'h11, 16'h8000);
        check("fsel_set", 32'(frame_sel), 32'd1);
        push_byte(8'h12, 16'h0000);
        check("fsel_held", 32'(frame_sel), 32'd1);
        end_frame(10);
        push_byte(8'h21, 16'h0000);
        check("fsel_clear", 32'(frame_sel), 32'd0);
        check("fsel_count_restart", 32'(byte_count), 32'd1);
        end_frame(10);

        // Reset with 5 bytes queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i), 16'h8000);
        check("mid_queued", 32'({out_valid, byte_count}), 32'h100005);
        tx_before = tx_cnt;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(byte_count), 32'd0);
        check("mid_rst_fsel", 32'(frame_sel), 32'd0);
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (5) cycle();
        check("mid_no_tx_done", 32'(tx_cnt), 32'(tx_before));
        check("mid_no_stale", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 16'h0000);
        end_frame(10);
        check("fresh_rx_size", 32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("fresh_rx_data", 32'(rx_q[i]), 32'hC0 + 32'(i));
        check("fresh_tx_pulses", 32'(tx_cnt), 32'(tx_before + 1));

`ifdef OUTPUT_CHECKSUM_EN
        // 300 x 0xFF: 76500 mod 65536 = 0x2AD4
        for (int i = 0; i < 300; i++) push_byte(8'hFF, 16'h0000);
        end_frame(10);
        check("csum_value", 32'(checksum), 32'h2AD4);
        check("csum_count", 32'(byte_count), 32'd300);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_stream_tx.md
OUTPUT_STREAM_TX -- requirements
Module: output_stream_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16; byte FIFO depth, power of 2, range 4..64.
REQ-002 Parameter CNT_W, default 20; byte_count width; covers 307200 bytes per frame (19200 words x 16 bytes).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  byte strobe from the output fetch stage (its StartOut).
REQ-006 in_data  input  8  byte from the fetch stage (its DataOut).
REQ-007 in_addr  input  16  word address from the fetch stage (its StoreAddress); bit 15 is the frame buffer select.
REQ-008 in_done  input  1  one-or-more-cycle end-of-frame indication from the fetch stage.
REQ-009 out_valid  output  1  out_data holds a valid byte.
REQ-010 out_data  output  8  byte to the external sink.
REQ-011 out_ready  input  1  sink accepts the byte; transfer occurs when out_valid and out_ready are both 1 on a rising edge.
REQ-012 frame_sel  output  1  in_addr[15] captured at frame start.
REQ-013 byte_count  output  CNT_W  bytes accepted into the FIFO in the current frame.
REQ-014 overflow  output  1  sticky; a byte was dropped in the current frame.
REQ-015 tx_done  output  1  single-cycle pulse; frame fully drained to the sink.

Function
REQ-016 FSM states IDLE, STREAM, DRAIN, DONE; state held in a registered encoding.
REQ-017 IDLE->STREAM on in_valid=1; same edge clears byte_count, overflow and the checksum, captures frame_sel=in_addr[15], and pushes the byte.
REQ-018 STREAM->DRAIN on in_done=1; in_valid bytes in that same cycle are still pushed.
REQ-019 DRAIN->DONE when the FIFO is empty and no byte is pending on the output (out_valid=0).
REQ-020 DONE: tx_done=1 for exactly one cycle, then DONE->IDLE unconditionally.
REQ-021 in_valid is ignored in DRAIN, DONE and IDLE except at the IDLE->STREAM edge.
REQ-022 Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-023 Push refused due to full: byte dropped, overflow set to 1; byte_count not incremented.
REQ-024 byte_count increments by 1 per accepted push and saturates at all-ones.
REQ-025 out_data/out_valid are registered; with an empty FIFO and out_ready=1, a byte pushed at edge N appears on out_data after edge N+1.
REQ-026 out_data is stable and out_valid stays 1 while out_ready=0.
REQ-027 Continuous push and pop with out_ready=1 sustains 1 byte/cycle without loss.
REQ-028 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty are derived from the MSB compare.

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE, FIFO empty, out_valid=0, out_data=0, frame_sel=0, byte_count=0, overflow=0, tx_done=0, checksum=0.
REQ-030 Reset mid-frame discards all FIFO contents; no tx_done is issued for that frame.

Configuration
REQ-031 Macro OUTPUT_CHECKSUM_EN defined: adds output checksum (16 bits), the sum modulo 2^16 of accepted bytes, cleared at frame start and frozen from DRAIN until the next frame start.
REQ-032 OUTPUT_CHECKSUM_EN undefined: no checksum port or logic; all other behaviour is identical.

Structure
REQ-033 Shared package output_pipe_pkg holds the FSM state enum, the frame byte total (307200) and the default FIFO_DEPTH.
REQ-034 Sub-module sync_byte_fifo (parameterised depth, push/pop/full/empty) is instantiated once.

Verification
REQ-035 Reset, then 16 bytes 0x00..0x0F with out_ready=1 -> out_data 0x00..0x0F in order, byte_count=16, then in_done -> tx_done pulses once.
REQ-036 out_ready=0, push 20 bytes at FIFO_DEPTH=16 -> overflow=1, byte_count=16; release ready -> first 16 bytes are delivered unchanged.
REQ-037 FIFO full, out_ready=1, push in the same cycle -> no drop, overflow stays 0.
REQ-038 in_addr=0x8000 on the first byte -> frame_sel=1; next frame with 0x0000 -> frame_sel=0, byte_count restarts from 1.
REQ-039 Assert reset_n=0 with 5 bytes in the FIFO -> out_valid=0 immediately, no tx_done, and the next frame delivers fresh bytes only.
REQ-040 With OUTPUT_CHECKSUM_EN, bytes 0xFF x 300 -> checksum=0x2AD4.
